// File: rtl/key_encoder_8to3.sv
// key_encoder_8to3: synchronised, debounced 8-to-3 priority encoder with valid strobe and held flag.
// Optional MULTI_KEY_ERR_EN builds a registered multi-key error flag; otherwise err is tied low.
module key_encoder_8to3 #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key,
  output logic [2:0] code,
  output logic       valid,
  output logic       held,
  output logic       err
);
  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;
  state_t state, state_n;
  logic [7:0] s1, ks, snap, snap_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0] code_n, enc;
  logic valid_n, last;
  assign last = cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
  assign held = state == PRESSED || state == RELEASE;
  always_comb begin
    enc = 3'd0;
    for (int i = 0; i < 8; i++) enc = snap[i] ? 3'(i) : enc;
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    snap_n = snap;
    code_n = code;
    valid_n = 1'b0;
    case (state)
      IDLE: if (ks != 8'd0) begin
        state_n = DEBOUNCE;
        snap_n = ks;
        cnt_n = '0;
      end
      DEBOUNCE: if (ks == 8'd0) state_n = IDLE;
      else if (ks != snap) begin
        snap_n = ks;
        cnt_n = '0;
      end else if (last) begin
        state_n = PRESSED;
        code_n = enc;
        valid_n = 1'b1;
      end else cnt_n = cnt + 1'b1;
      PRESSED: if (ks == 8'd0) begin
        state_n = RELEASE;
        cnt_n = '0;
      end
      default: if (ks != 8'd0) begin
        state_n = PRESSED;
        cnt_n = '0;
      end else if (last) state_n = IDLE;
      else cnt_n = cnt + 1'b1;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '0;
      ks <= '0;
      state <= IDLE;
      cnt <= '0;
      snap <= '0;
      code <= '0;
      valid <= 1'b0;
    end else begin
      s1 <= key;
      ks <= s1;
      state <= state_n;
      cnt <= cnt_n;
      snap <= snap_n;
      code <= code_n;
      valid <= valid_n;
    end
`ifdef MULTI_KEY_ERR_EN
  // clearing the lowest set bit leaves something only if two or more bits were set
  always_ff @(posedge clk or posedge rst)
    if (rst) err <= 1'b0;
    else if (valid_n) err <= |(snap & (snap - 8'd1));
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_key_encoder_8to3.sv
// tb_key_encoder_8to3: scoreboard bench for key_encoder_8to3; expected valid events queued at drive time.
module tb_key_encoder_8to3;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] key = 8'd0;
  logic [2:0] code;
  logic valid, held, err;
  int unsigned cyc = 0;
  int n_checks = 0, n_fail = 0;
  typedef struct {
    int unsigned cyc;
    logic [2:0] code;
    logic err;
  } exp_t;
  exp_t q[$];
  key_encoder_8to3 dut (.clk(clk), .rst(rst), .key(key), .code(code), .valid(valid), .held(held), .err(err));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [2:0] enc(input logic [7:0] k);
    enc = 3'd0;
    for (int i = 7; i >= 0; i--) if (k[i]) return 3'(i);
  endfunction
  function automatic logic exp_err(input logic [7:0] k);
`ifdef MULTI_KEY_ERR_EN
    return $countones(k) > 1;
`else
    return 1'b0;
`endif
  endfunction
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  // a clean press from IDLE strobes valid after the 7th rising edge from now
  task automatic press(input logic [7:0] k);
    q.push_back('{cyc + 7, enc(k), exp_err(k)});
    key = k;
  endtask
  always @(negedge clk)
    if (!rst && valid) begin
      if (q.size() == 0) check("spurious_valid", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("valid_cycle", cyc, e.cyc);
        check("valid_code", {29'd0, code}, {29'd0, e.code});
        check("valid_err", {31'd0, err}, {31'd0, e.err});
      end
    end
  initial begin
    step(3);
    check("rst_code", {29'd0, code}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_held", {31'd0, held}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    step(3);
    press(8'h08);
    step(20);
    check("single_held", {31'd0, held}, 32'd1);
    check("single_code", {29'd0, code}, 32'd3);
    key = 8'h00;
    step(6);
    check("release_held_last", {31'd0, held}, 32'd1);
    step(1);
    check("release_held_done", {31'd0, held}, 32'd0);
    check("idle_code_holds", {29'd0, code}, 32'd3);
    step(5);
    press(8'h81);
    step(12);
    check("prio_code7", {29'd0, code}, 32'd7);
    key = 8'h00;
    step(12);
    press(8'h01);
    step(12);
    check("prio_code0", {29'd0, code}, 32'd0);
    key = 8'h00;
    step(12);
    for (int i = 0; i < 3; i++) begin
      key = 8'h10;
      step(2);
      key = 8'h00;
      step(2);
    end
    check("bounce_no_press", {31'd0, held}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      key = 8'h10;
      step(2);
      key = 8'h00;
      step(2);
    end
    press(8'h10);
    step(14);
    check("bounce_code", {29'd0, code}, 32'd4);
    key = 8'h00;
    step(12);
    press(8'h04);
    step(12);
    key = 8'h40;
    step(10);
    check("held_change_code", {29'd0, code}, 32'd2);
    key = 8'h00;
    step(3);
    key = 8'h40;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("short_release_held", {31'd0, held}, 32'd1);
    end
    check("short_release_code", {29'd0, code}, 32'd2);
    key = 8'h00;
    step(12);
    check("released_held", {31'd0, held}, 32'd0);
    press(8'h24);
    step(12);
    check("multi_code", {29'd0, code}, 32'd5);
    check("multi_err", {31'd0, err}, {31'd0, exp_err(8'h24)});
    key = 8'h00;
    step(12);
    check("err_holds", {31'd0, err}, {31'd0, exp_err(8'h24)});
    press(8'h02);
    step(12);
    check("single_err", {31'd0, err}, 32'd0);
    key = 8'h00;
    step(12);
    press(8'h08);
    step(10);
    check("pre_rst_held", {31'd0, held}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_code", {29'd0, code}, 32'd0);
    check("async_valid", {31'd0, valid}, 32'd0);
    check("async_held", {31'd0, held}, 32'd0);
    check("async_err", {31'd0, err}, 32'd0);
    key = 8'h00;
    step(2);
    rst = 1'b0;
    step(3);
    check("post_rst_held", {31'd0, held}, 32'd0);
    press(8'h20);
    step(12);
    check("post_rst_code", {29'd0, code}, 32'd5);
    key = 8'h00;
    step(12);
    check("sb_empty", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
